// File: rtl/ef_pwm32_shadow_ctrl_pkg.sv
// Shared types and constants for the PWM32 shadow-config controller.
// Latency: n/a (declarations only). Backpressure: n/a.
package ef_pwm32_pkg;

    localparam int PWM_W    = 32;
    localparam int PWM_CDW  = 4;
    localparam int PWM_CNTW = 8;

    localparam logic [PWM_W-1:0]   RST_CMP_DEF    = '0;
    localparam logic [PWM_W-1:0]   RST_TOP_DEF    = '0;
    localparam logic [PWM_CDW-1:0] RST_CLKDIV_DEF = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        COMMIT = 2'd2
    } updState_t;

endpackage

// File: rtl/ef_pwm32_shadow_ctrl_if.sv
// Staging-side and active-side signals of the PWM32 shadow controller.
// Latency: n/a (wiring). Backpressure: none; upd_req/upd_cancel are single-cycle pulses.
interface ef_pwm32_shadow_ctrl_if
    import ef_pwm32_pkg::*;
#(
    parameter int W    = PWM_W,
    parameter int CDW  = PWM_CDW,
    parameter int CNTW = PWM_CNTW
);
    logic [W-1:0]    cmp_a_i;
    logic [W-1:0]    cmp_b_i;
    logic [W-1:0]    top_i;
    logic [CDW-1:0]  clkdiv_i;
    logic [CNTW-1:0] upd_cnt;
    logic            upd_req;
    logic            upd_cancel;
    logic            en;
    logic            period_tick;
    logic [W-1:0]    cmp_a_o;
    logic [W-1:0]    cmp_b_o;
    logic [W-1:0]    top_o;
    logic [CDW-1:0]  clkdiv_o;
    logic            busy;
    logic            upd_done;
`ifdef EF_PWM32_UPD_IRQ_EN
    logic            upd_irq;
    logic            irq_clr;

    modport master (
        output cmp_a_i, cmp_b_i, top_i, clkdiv_i, upd_cnt, upd_req, upd_cancel, en, period_tick, irq_clr,
        input  cmp_a_o, cmp_b_o, top_o, clkdiv_o, busy, upd_done, upd_irq
    );
    modport slave (
        input  cmp_a_i, cmp_b_i, top_i, clkdiv_i, upd_cnt, upd_req, upd_cancel, en, period_tick, irq_clr,
        output cmp_a_o, cmp_b_o, top_o, clkdiv_o, busy, upd_done, upd_irq
    );
`else
    modport master (
        output cmp_a_i, cmp_b_i, top_i, clkdiv_i, upd_cnt, upd_req, upd_cancel, en, period_tick,
        input  cmp_a_o, cmp_b_o, top_o, clkdiv_o, busy, upd_done
    );
    modport slave (
        input  cmp_a_i, cmp_b_i, top_i, clkdiv_i, upd_cnt, upd_req, upd_cancel, en, period_tick,
        output cmp_a_o, cmp_b_o, top_o, clkdiv_o, busy, upd_done
    );
`endif
endinterface

// File: rtl/ef_pwm32_shadow_ctrl_bnd_cnt.sv
// Loadable down-counter of remaining period boundaries; saturates at zero.
// Latency: load/decrement visible the cycle after. Backpressure: none; load beats decrement.
module ef_pwm32_bnd_cnt #(
    parameter int CNTW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [CNTW-1:0] loadVal,
    input  logic            dec,
    output logic            zero
);
    logic [CNTW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= loadVal;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ef_pwm32_shadow_ctrl.sv
// Double-buffered cmp_a/cmp_b/top/clkdiv, committed atomically at a PWM period boundary (optional IRQ: EF_PWM32_UPD_IRQ_EN).
// Latency: >=2 cycles upd_req->new values; commit on the edge sampling the qualifying tick, or next edge if en=0.
// Backpressure: none; a new upd_req overrides a pending one, upd_cancel drops it.
module ef_pwm32_shadow_ctrl
    import ef_pwm32_pkg::*;
#(
    parameter int           W       = PWM_W,
    parameter int           CDW     = PWM_CDW,
    parameter int           CNTW    = PWM_CNTW,
    parameter logic [W-1:0] RST_TOP = W'(RST_TOP_DEF)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    ef_pwm32_shadow_ctrl_if.slave  bus
);
    updState_t       state, stateNxt;
    logic            cntZero;
    logic            cntDec;
    logic            commitNow;

    logic [W-1:0]    pendCmpA, pendCmpB, pendTop;
    logic [CDW-1:0]  pendClkdiv;
    logic [W-1:0]    actCmpA, actCmpB, actTop;
    logic [CDW-1:0]  actClkdiv;

    ef_pwm32_bnd_cnt #(.CNTW(CNTW)) uBndCnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (bus.upd_req),
        .loadVal (bus.upd_cnt),
        .dec     (cntDec),
        .zero    (cntZero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNxt;
        end
    end

    // In ARMED the priority is request > cancel > timer stopped > boundary tick.
    always_comb begin
        stateNxt  = state;
        cntDec    = 1'b0;
        commitNow = 1'b0;
        case (state)
            IDLE: begin
                if (bus.upd_req) stateNxt = ARMED;
            end
            ARMED: begin
                if (bus.upd_req) begin
                    stateNxt = ARMED;
                end else if (bus.upd_cancel) begin
                    stateNxt = IDLE;
                end else if (!bus.en) begin
                    stateNxt  = COMMIT;
                    commitNow = 1'b1;
                end else if (bus.period_tick) begin
                    if (cntZero) begin
                        stateNxt  = COMMIT;
                        commitNow = 1'b1;
                    end else begin
                        cntDec = 1'b1;
                    end
                end
            end
            COMMIT: begin
                stateNxt = bus.upd_req ? ARMED : IDLE;
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendCmpA   <= '0;
            pendCmpB   <= '0;
            pendTop    <= '0;
            pendClkdiv <= '0;
        end else if (bus.upd_req) begin
            pendCmpA   <= bus.cmp_a_i;
            pendCmpB   <= bus.cmp_b_i;
            pendTop    <= bus.top_i;
            pendClkdiv <= bus.clkdiv_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            actCmpA   <= W'(RST_CMP_DEF);
            actCmpB   <= W'(RST_CMP_DEF);
            actTop    <= RST_TOP;
            actClkdiv <= CDW'(RST_CLKDIV_DEF);
        end else if (commitNow) begin
            actCmpA   <= pendCmpA;
            actCmpB   <= pendCmpB;
            actTop    <= pendTop;
            actClkdiv <= pendClkdiv;
        end
    end

    assign bus.cmp_a_o  = actCmpA;
    assign bus.cmp_b_o  = actCmpB;
    assign bus.top_o    = actTop;
    assign bus.clkdiv_o = actClkdiv;
    assign bus.busy     = (state == ARMED);
    assign bus.upd_done = (state == COMMIT);

`ifdef EF_PWM32_UPD_IRQ_EN
    logic updIrq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            updIrq <= 1'b0;
        end else if (state == COMMIT) begin
            updIrq <= 1'b1;
        end else if (bus.irq_clr) begin
            updIrq <= 1'b0;
        end
    end

    assign bus.upd_irq = updIrq;
`endif

endmodule
